// File: rtl/csr_timer_pkg.sv
// Shared definitions for the constant timer CSR block.
package csr_timer_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CNT_W  = 64;
  localparam int unsigned TI_BIT = 11;

  localparam logic [13:0] CSR_TID   = 14'h040;
  localparam logic [13:0] CSR_TCFG  = 14'h041;
  localparam logic [13:0] CSR_TVAL  = 14'h042;
  localparam logic [13:0] CSR_TICLR = 14'h044;

  // TCFG layout: [0] en, [1] periodic, [31:2] initval
  typedef struct packed {
    logic [29:0] initval;
    logic        periodic;
    logic        en;
  } tcfg_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_t;

  // Mask keeping the low n bits of a 32-bit timer value.
  function automatic logic [31:0] timer_mask(input int unsigned n);
    if (n >= 32) return 32'hFFFF_FFFF;
    return 32'((64'd1 << n) - 64'd1);
  endfunction

endpackage

// File: rtl/csr_timer_stable_counter.sv
// Free-running stable counter read by rdcnt* instructions.
module csr_timer_stable_counter #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] cnt_o
);

  // Increment every cycle, wrapping naturally at 2^W.
  always_ff @(posedge clk) begin
    if (rst) cnt_o <= '0;
    else     cnt_o <= cnt_o + W'(1);
  end

endmodule

// File: rtl/csr_timer.sv
// Per-core constant timer (TCFG/TVAL/TID/TICLR) plus the 64-bit stable counter.
module csr_timer
  import csr_timer_pkg::*;
#(
  parameter int unsigned TIMER_N = 32,
  parameter logic [31:0] CORE_ID = 32'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tcfg_we,
  input  logic [XLEN-1:0]  tcfg_wdata,
  input  logic             ticlr_we,
  input  logic [XLEN-1:0]  ticlr_wdata,
  input  logic             tid_we,
  input  logic [XLEN-1:0]  tid_wdata,
  output logic [XLEN-1:0]  tcfg_o,
  output logic [XLEN-1:0]  tval_o,
  output logic [XLEN-1:0]  tid_o,
  output logic [XLEN-1:0]  ticlr_o,
  output logic             ti_o,
  output logic [CNT_W-1:0] stable_cnt_o
);

  localparam logic [XLEN-1:0] TVAL_MASK = timer_mask(TIMER_N);

  timer_state_t    state_q, state_d;
  tcfg_t           tcfg_q, tcfg_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] tid_q, tid_d;
  logic            ti_q, ti_d;

  tcfg_t           tcfg_wr;
  logic [XLEN-1:0] reload_wr;
  logic [XLEN-1:0] reload_q;
  logic            expire;
  logic            unused_ticlr;

  // Bits above the implemented width never reach TCFG or TVAL.
  assign tcfg_wr      = tcfg_t'(tcfg_wdata & TVAL_MASK);
  assign reload_wr    = {tcfg_wr.initval, 2'b00};
  assign reload_q     = {tcfg_q.initval, 2'b00};
  assign expire       = (state_q == RUN) && (tval_q == '0);
  assign unused_ticlr = ^ticlr_wdata[XLEN-1:1];

  // Timer state, TCFG/TVAL/TID and sticky interrupt registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tcfg_q  <= '0;
      tval_q  <= TVAL_MASK;
      tid_q   <= CORE_ID;
      ti_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tcfg_q  <= tcfg_d;
      tval_q  <= tval_d;
      tid_q   <= tid_d;
      ti_q    <= ti_d;
    end
  end

  // Countdown, expiry handling and CSR write effects.
  always_comb begin
    state_d = state_q;
    tcfg_d  = tcfg_q;
    tval_d  = tval_q;
    tid_d   = tid_q;
    ti_d    = ti_q;

    unique case (state_q)
      RUN: begin
        if (tval_q != '0) begin
          tval_d = tval_q - XLEN'(1);
        end else if (tcfg_q.periodic) begin
          tval_d = reload_q;
        end else begin
          tval_d  = TVAL_MASK;
          state_d = DONE;
        end
      end
      IDLE, DONE: ;
      default: state_d = IDLE;
    endcase

    // A TCFG write overrides whatever the countdown did this cycle.
    if (tcfg_we) begin
      tcfg_d = tcfg_wr;
      if (tcfg_wr.en) begin
        tval_d  = reload_wr;
        state_d = RUN;
      end else begin
        tval_d  = tval_q;
        state_d = IDLE;
      end
    end

    if (tid_we) tid_d = tid_wdata;

    // Expiry wins over a clear landing in the same cycle.
    if (ticlr_we && ticlr_wdata[0]) ti_d = 1'b0;
    if (expire)                     ti_d = 1'b1;
  end

  assign tcfg_o  = XLEN'(tcfg_q);
  assign tval_o  = tval_q;
  assign tid_o   = tid_q;
  assign ti_o    = ti_q;
  assign ticlr_o = '0;

  csr_timer_stable_counter #(.W(CNT_W)) u_stable_counter (
    .clk   (clk),
    .rst   (rst),
    .cnt_o (stable_cnt_o)
  );

endmodule

// File: doc/csr_timer.md
# csr_timer

Per-core constant timer and stable counter: owns TCFG, TVAL, TID and TICLR state; counts TVAL down each cycle; produces the timer interrupt `ti_o` consumed by the exception unit's `ti_in`. Also provides the free-running 64-bit stable counter used by `rdcnt*` instructions. Sits beside the CSR file, written by the WB-stage CSR write path.

## Interface
- `TIMER_N`, 32, implemented timer width (8..32); TCFG.initval/TVAL bits ≥ TIMER_N read as 0
- `CORE_ID`, 0, TID reset value
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `tcfg_we`  in  1  TCFG write strobe (WB stage)
- `tcfg_wdata`  in  32  TCFG write data: [0] en, [1] periodic, [TIMER_N-1:2] initval
- `ticlr_we`  in  1  TICLR write strobe
- `ticlr_wdata`  in  32  bit 0 = CLR (write-1 clears timer interrupt); other bits ignored
- `tid_we`  in  1  TID write strobe
- `tid_wdata`  in  32  TID write data
- `tcfg_o`  out  32  current TCFG
- `tval_o`  out  32  current TVAL
- `tid_o`  out  32  current TID
- `ticlr_o`  out  32  always 0 (TICLR reads as zero)
- `ti_o`  out  1  timer interrupt pending, ESTAT.IS[11] source, to exception `ti_in`
- `stable_cnt_o`  out  64  stable counter

## Operation
- Reset values: tcfg_o=0, tval_o=32'hFFFF_FFFF masked to TIMER_N bits, tid_o=CORE_ID, ti_o=0, stable_cnt_o=0, state IDLE.
- Stable counter: +1 every cycle after reset, wraps 2^64-1 → 0; not writable.
- Reload value R = {initval, 2'b00}, zero-extended from TIMER_N.
- States:
  - IDLE: TVAL holds.
  - RUN: if TVAL≠0, TVAL−1. If TVAL==0: ti set; periodic → TVAL=R, stay RUN; one-shot → TVAL=all-ones (TIMER_N bits), go DONE.
  - DONE: TVAL holds, no further expiry until rearmed.
- TCFG write (priority over countdown, any state): TCFG latched. en=1 → TVAL=R, state RUN. en=0 → state IDLE, TVAL keeps its current value (countdown result of that cycle is discarded).
- ti: sticky. Set on expiry; cleared by `ticlr_we` with wdata[0]=1. Clear with wdata[0]=0 has no effect. Expiry and clear in the same cycle → ti=1 (set wins). TCFG write does not touch ti.
- TID write: tid=wdata; no side effects.
- initval=0 with en=1: TVAL=0, expires on the next cycle. Periodic with R=0 → ti re-set every cycle.

## Timing
- All outputs registered; every write is visible on outputs the cycle after its strobe.
- TCFG write (en=1, R=V) in cycle 0 → tval_o=V in cycle 1, reaches 0 in cycle 1+V, ti_o=1 in cycle 2+V; periodic: tval_o=V again in cycle 2+V, next ti set in cycle 3+2V.
- TICLR write in cycle t → ti_o=0 in cycle t+1, unless an expiry occurs in cycle t.
- rst mid-count: all state returns to reset values next cycle; a pending ti is dropped.

## Structure
- Shared package `cpu_defs`: `tcfg_t` packed struct (en, periodic, initval), `timer_state_t` enum {IDLE, RUN, DONE}, CSR address constants for TCFG/TVAL/TICLR/TID, TI bit index 11.
- Sub-module `stable_counter` (64-bit free-running counter, clk/rst/cnt_o) is natural; everything else inline.

## Test plan
- Reset → tcfg_o=0, tval_o=32'hFFFFFFFF, ti_o=0, tid_o=CORE_ID; stable_cnt_o=N after N cycles.
- TCFG write 32'h0000_0011 (en, one-shot, R=16) → tval_o=16, then 0 at +16 cycles, ti_o=1 next cycle, tval_o=32'hFFFFFFFF, holds; no second ti after TICLR.
- TCFG write 32'h0000_000B (en, periodic, R=8) → ti_o set every 9 cycles; TICLR bit0=1 between expiries → ti_o drops for 1+ cycles, then reasserts at next expiry.
- TICLR (bit0=1) in the exact expiry cycle → ti_o remains 1; TICLR with bit0=0 → ti_o unchanged.
- Mid-count TCFG write en=0 at tval_o=5 → tval_o stays 5, no ti; rewrite en=1, R=4 → tval_o=4 next cycle, count restarts.
- rst asserted while RUN with ti_o=1 → all outputs at reset values next cycle; stable counter restarts at 0.
